// File: rtl/als_pkg.sv
// Shared types and constants for the PmodALS SPI read sequencer.
// Not timed logic: holds the FSM encoding, control-register bit positions and frame layout only.
package als_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        WRITE_BACK
    } als_state_t;

    localparam int START_BIT  = 0;
    localparam int DONE_BIT   = 1;

    // ADC081S021 frame: 3 leading zeros, 8 data bits MSB-first, 5 trailing bits
    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 12;
    localparam int DATA_LSB   = 5;

    // Control register [1:0] after a conversion: START cleared, DONE set
    localparam logic [1:0] WB_CODE = 2'b10;

endpackage

// File: rtl/generador_sclk.sv
// SCLK divider: HALF_PERIOD clk cycles per half-period, idles high; sclk is a flop, ticks are decoded from state.
// No backpressure: runs while enable is high, snaps back to sclk=1 / count 0 when enable drops.
module generador_sclk
    import als_pkg::*;
#(
    parameter int HALF_PERIOD = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sclk,
    output logic rise_tick,
    output logic period_done
);

    localparam int            CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          half_end;

    assign half_end = (cnt == LAST);

    // Ticks are not gated by enable: the parent derives enable from period_done,
    // and with enable low the counter sits at 0, so neither tick can fire.
    assign rise_tick   = half_end && !sclk;
    assign period_done = half_end && sclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!enable) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (half_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_spi_als.sv
// Reads one PmodALS sample per START: CS setup, 16 SCLK periods, CS hold, one-cycle write-back; 34*HALF_PERIOD+1 cycles.
// No backpressure: the register writes are fire-and-forget strobes; START changes mid-frame are ignored.
module controlador_spi_als
    import als_pkg::*;
#(
    parameter int HALF_PERIOD = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ctrl_in,
    output logic        wr2_c,
    output logic [1:0]  in2,
    output logic        wr_d,
    output logic [31:0] data_out,
    output logic        cs_n,
    output logic        sclk,
    input  logic        miso,
    output logic        busy
);

    localparam int            CW        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [4:0]    LAST_BIT  = 5'(FRAME_BITS - 1);

    als_state_t              state;
    logic [FRAME_BITS-1:0]   frame;
    logic [4:0]              bit_cnt;
    logic [CW-1:0]           hold_cnt;
    logic                    gen_en;
    logic                    rise_tick;
    logic                    period_done;
    logic                    unused_ctrl;

    // DONE and the upper control bits belong to the processor side.
    assign unused_ctrl = ^ctrl_in[31:1];

    // CS_SETUP doubles as the idle-high half before the first falling edge.
    // Dropping enable on the final period keeps sclk high through CS_HOLD.
    assign gen_en = (state == CS_SETUP) ||
                    ((state == SHIFT) && !(period_done && (bit_cnt == LAST_BIT)));

    generador_sclk #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk (
        .clk         (clk),
        .rst         (rst),
        .enable      (gen_en),
        .sclk        (sclk),
        .rise_tick   (rise_tick),
        .period_done (period_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            wr2_c    <= 1'b0;
            in2      <= 2'b00;
            wr_d     <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            frame    <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            wr2_c <= 1'b0;
            in2   <= 2'b00;
            wr_d  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_in[START_BIT]) begin
                        state <= CS_SETUP;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                CS_SETUP: begin
                    if (period_done) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_tick) begin
                        frame <= {frame[FRAME_BITS-2:0], miso};
                    end
                    if (period_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= CS_HOLD;
                            cs_n    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                CS_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= WRITE_BACK;
                        wr_d     <= 1'b1;
                        data_out <= {24'b0, frame[DATA_MSB:DATA_LSB]};
                        wr2_c    <= 1'b1;
                        in2      <= WB_CODE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WRITE_BACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_spi_als.sv
// Bench for controlador_spi_als: a default build and a HALF_PERIOD=2 build against a sensor model,
// a processor-side control register model and expected values built from the sample byte.
module tb_controlador_spi_als;

    localparam int HP0 = 5;
    localparam int HP1 = 2;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic [31:0] ctrl     [2] = '{32'hA5A5_0000, 32'h5A5A_0000};
    logic        wr2_c    [2];
    logic [1:0]  in2      [2];
    logic        wr_d     [2];
    logic [31:0] data_out [2];
    logic        cs_n     [2];
    logic        sclk     [2];
    logic        miso     [2] = '{1'b0, 1'b0};
    logic        busy     [2];

    logic        cpu_set   [2];
    logic [15:0] tx_frame  [2];
    int          rises     [2] = '{0, 0};
    int          idx       [2] = '{0, 0};
    logic        sclk_prev [2] = '{1'b1, 1'b1};
    logic        cs_prev   [2] = '{1'b1, 1'b1};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    controlador_spi_als #(.HALF_PERIOD(HP0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .ctrl_in(ctrl[0]), .wr2_c(wr2_c[0]), .in2(in2[0]),
        .wr_d(wr_d[0]), .data_out(data_out[0]), .cs_n(cs_n[0]), .sclk(sclk[0]),
        .miso(miso[0]), .busy(busy[0])
    );

    controlador_spi_als #(.HALF_PERIOD(HP1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .ctrl_in(ctrl[1]), .wr2_c(wr2_c[1]), .in2(in2[1]),
        .wr_d(wr_d[1]), .data_out(data_out[1]), .cs_n(cs_n[1]), .sclk(sclk[1]),
        .miso(miso[1]), .busy(busy[1])
    );

    // Control register: peripheral write to [1:0], processor START write OR'd on top.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr2_c[k]) ctrl[k][1:0] <= in2[k];
            if (cpu_set[k]) ctrl[k][0] <= 1'b1;
        end
    end

    // Sensor: junk when CS falls, next frame bit after each SCLK fall; also counts SCLK rises under CS.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs_prev[k] && !cs_n[k]) begin
                idx[k]  = 16;
                miso[k] = ($urandom & 1) != 0;
            end
            if (!cs_n[k] && sclk_prev[k] && !sclk[k] && idx[k] > 0) begin
                idx[k]  = idx[k] - 1;
                miso[k] = tx_frame[k][idx[k]];
            end
            if (!cs_n[k] && !sclk_prev[k] && sclk[k]) rises[k] = rises[k] + 1;
            sclk_prev[k] = sclk[k];
            cs_prev[k]   = cs_n[k];
        end
    end

    function automatic int hp(input int k);
        return (k == 0) ? HP0 : HP1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load a frame around sample d and pulse START; returns at the cycle the DUT sees START.
    task automatic kick(input int k, input logic [7:0] d, input logic [2:0] jh, input logic [4:0] jl);
        tx_frame[k] = {jh, d, jl};
        @(negedge clk);
        cpu_set[k] = 1'b1;
        @(negedge clk);
        cpu_set[k] = 1'b0;
    endtask

    // Called at the cycle where IDLE sees START=1; follows the frame through write-back.
    task automatic run_frame(input int k, input logic [7:0] d, input bit retrig,
                             input logic [7:0] d_next, input string tag);
        int t, t_cs, t_fall, t_rise, t_wb, r0, h;
        logic [31:0] exp_dat;
        h = hp(k);
        r0 = rises[k];
        exp_dat = {24'h0, d};
        t = 0; t_cs = -1; t_fall = -1; t_rise = -1; t_wb = -1;
        while (t < 40 * h + 20 && t_wb < 0) begin
            @(negedge clk);
            t++;
            if (t == 1) chk({tag, "/busy_run"}, busy[k], 1'b1);
            if (!cs_n[k] && t_cs < 0) t_cs = t;
            if (!sclk[k] && t_fall < 0) t_fall = t;
            if (t_cs >= 0 && cs_n[k] && t_rise < 0) t_rise = t;
            if (wr_d[k]) t_wb = t;
        end
        chk({tag, "/cs_fall"}, t_cs, 1);
        chk({tag, "/setup"}, t_fall, 1 + h);
        chk({tag, "/cs_rise"}, t_rise, 33 * h + 1);
        chk({tag, "/latency"}, t_wb, 34 * h + 1);
        chk({tag, "/rises"}, rises[k] - r0, 16);
        chk({tag, "/data"}, data_out[k], exp_dat);
        chk({tag, "/wr2_c"}, wr2_c[k], 1'b1);
        chk({tag, "/in2"}, in2[k], 2'b10);
        if (retrig) begin
            cpu_set[k] = 1'b1;
            tx_frame[k] = {3'($urandom), d_next, 5'($urandom)};
        end
        @(negedge clk);
        cpu_set[k] = 1'b0;
        chk({tag, "/wr_d_once"}, wr_d[k], 1'b0);
        chk({tag, "/wr2_c_once"}, wr2_c[k], 1'b0);
        chk({tag, "/in2_idle"}, in2[k], 2'b00);
        chk({tag, "/data_hold"}, data_out[k], exp_dat);
        chk({tag, "/busy_idle"}, busy[k], 1'b0);
        chk({tag, "/ctrl"}, ctrl[k][1:0], retrig ? 2'b11 : 2'b10);
    endtask

    initial begin
        logic [7:0] d, d2;
        int n, r0, strobes;

        rst[0] = 1'b0; rst[1] = 1'b0;
        cpu_set[0] = 1'b1; cpu_set[1] = 1'b1;
        tx_frame[0] = '0; tx_frame[1] = '0;
        repeat (3) @(negedge clk);
        cpu_set[0] = 1'b0; cpu_set[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst/cs_n", cs_n[k], 1'b1);
            chk("rst/sclk", sclk[k], 1'b1);
            chk("rst/busy", busy[k], 1'b0);
            chk("rst/wr_d", wr_d[k], 1'b0);
            chk("rst/wr2_c", wr2_c[k], 1'b0);
            chk("rst/in2", in2[k], 2'b00);
            chk("rst/data", data_out[k], 32'h0);
        end

        // Release with START already set: the conversion starts on the next edge.
        tx_frame[0] = 16'b000_10110011_00000;
        rst[0] = 1'b1;
        run_frame(0, 8'hB3, 1'b0, 8'h00, "single");

        kick(0, 8'h00, 3'b111, 5'b11111);
        run_frame(0, 8'h00, 1'b0, 8'h00, "zero");
        kick(0, 8'hFF, 3'b000, 5'b00000);
        run_frame(0, 8'hFF, 1'b0, 8'h00, "ones");

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            kick(0, d, 3'($urandom), 5'($urandom));
            run_frame(0, d, 1'b0, 8'h00, "rand");
        end

        d = 8'($urandom); d2 = 8'($urandom);
        kick(0, d, 3'($urandom), 5'($urandom));
        run_frame(0, d, 1'b1, d2, "b2b_first");
        run_frame(0, d2, 1'b0, 8'h00, "b2b_second");

        // Abort in the low half of the eighth SCLK period.
        d = 8'($urandom);
        kick(0, d, 3'($urandom), 5'($urandom));
        r0 = rises[0];
        n = 0;
        while (!((rises[0] - r0) >= 7 && !sclk[0]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort/reached", n < 500, 1'b1);
        rst[0] = 1'b0;
        #1;
        chk("abort/cs_n", cs_n[0], 1'b1);
        chk("abort/sclk", sclk[0], 1'b1);
        chk("abort/busy", busy[0], 1'b0);
        chk("abort/data", data_out[0], 32'h0);
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_d[0] || wr2_c[0]) strobes++;
        end
        chk("abort/strobes", strobes, 0);
        d = 8'($urandom);
        tx_frame[0] = {3'($urandom), d, 5'($urandom)};
        rst[0] = 1'b1;
        run_frame(0, d, 1'b0, 8'h00, "after_abort");

        // Fast build: SCLK period 4 clk, 2-cycle setup and hold.
        d = 8'($urandom);
        tx_frame[1] = {3'($urandom), d, 5'($urandom)};
        rst[1] = 1'b1;
        run_frame(1, d, 1'b0, 8'h00, "hp2_first");
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            kick(1, d, 3'($urandom), 5'($urandom));
            run_frame(1, d, 1'b0, 8'h00, "hp2_rand");
        end
        d = 8'($urandom); d2 = 8'($urandom);
        kick(1, d, 3'($urandom), 5'($urandom));
        run_frame(1, d, 1'b1, d2, "hp2_b2b_first");
        run_frame(1, d2, 1'b0, 8'h00, "hp2_b2b_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controlador_spi_als.md
Name: controlador_spi_als

Overview:
- Sequences one read of the ambient-light sensor (PmodALS, ADC081S021, 8-bit SPI ADC) each time the processor sets the START bit of the 32-bit control register.
- Runs the SPI frame and writes the 8-bit result, zero-extended, to the data register.
- Writes bits [1:0] of the control register through its peripheral write port (wr2_c/in2): clears START, sets DONE.
- Sits between the control register, the data register and the sensor pins.

Parameters:
- HALF_PERIOD, 5, clk cycles per SCLK half-period. At 10 MHz clk this gives 1 MHz SCLK. Legal range is 2 or more.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ctrl_in  in  32  current control register value; bit0 = START, bit1 = DONE, other bits ignored
- wr2_c  out  1  one-cycle write strobe to the control register low field
- in2  out  2  value for control register [1:0]; always 2'b10 when wr2_c=1, 2'b00 otherwise
- wr_d  out  1  one-cycle write strobe to the data register
- data_out  out  32  {24'b0, sample[7:0]}; valid when wr_d=1
- cs_n  out  1  sensor chip select, active low
- sclk  out  1  SPI clock, idles high
- miso  in  1  sensor serial data
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, cs_n=1, sclk=1, wr2_c=0, in2=2'b00, wr_d=0, data_out=0, busy=0, and all counters and the shift register are 0.
- IDLE: if ctrl_in[0]=1, go to CS_SETUP on the next edge. cs_n falls on that same edge.
- CS_SETUP: cs_n=0, sclk=1 for HALF_PERIOD cycles, then go to SHIFT.
- SHIFT: 16 SCLK periods. Each period is HALF_PERIOD cycles with sclk=0, then HALF_PERIOD cycles with sclk=1.
  - miso is sampled on the clk edge that drives sclk 0->1.
  - The sample shifts MSB-first into a 16-bit frame register.
  - A 5-bit bit counter runs 0..15. After the 16th high half, go to CS_HOLD.
- CS_HOLD: cs_n=1, sclk=1 for HALF_PERIOD cycles, then go to WRITE_BACK.
- WRITE_BACK: exactly one cycle.
  - wr_d=1, data_out={24'b0, frame[12:5]}.
  - wr2_c=1, in2=2'b10.
  - Next state is IDLE.
- Latency: from the IDLE cycle that sees START to the WRITE_BACK cycle is 34*HALF_PERIOD+1 cycles (171 at default).
- Re-trigger: the control register updates on the edge that leaves WRITE_BACK, so IDLE sees START=0.
  - If the processor writes START=1 in the WRITE_BACK cycle, the register ORs the two writes, bit0 stays 1, and a new conversion starts immediately. This is intended.
- START cleared by the processor mid-frame is ignored. The frame completes and write-back still occurs.
- DONE (ctrl_in[1]) is never read by this block. The processor clears it.
- Reset mid-frame: immediate return to reset values. cs_n goes high asynchronously. No write strobe is issued.
- data_out holds its last value outside WRITE_BACK.
- Divider counter width: $clog2(HALF_PERIOD).

Decomposition:
- Package als_pkg holds:
  - typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, WRITE_BACK} als_state_t
  - START_BIT=0, DONE_BIT=1
  - FRAME_BITS=16, DATA_MSB=12, DATA_LSB=5
  - WB_CODE=2'b10
- One sub-module, generador_sclk: HALF_PERIOD divider.
  - Enable input; outputs sclk, rise_tick (the cycle before sclk 0->1) and period_done.
  - Reset and disable force sclk=1 and the counter to 0.
- FSM, frame shift register and write-back logic stay in the top module.

Test Plan:
- Reset: hold rst=0 with ctrl_in[0]=1 → cs_n=1, sclk=1, busy=0, no strobes. Release rst → cs_n falls on the next edge.
- Single read: sensor model drives frame 16'b000_10110011_00000 and the bench pulses START → exactly 16 SCLK rises, data_out=32'h0000_00B3 with wr_d=1 for one cycle. Same cycle: wr2_c=1, in2=2'b10, 171 cycles after the detect cycle.
- Boundary values: frames carrying 8'h00 and 8'hFF → data_out=0 and 32'h0000_00FF. Junk in frame bits [15:13] and [4:0] does not leak into data_out.
- Back-to-back: bench asserts START again in the WRITE_BACK cycle (register ORs the writes) → second frame begins with no IDLE dwell beyond one cycle, and both results are written.
- Abort: assert rst at bit 7 of SHIFT → cs_n=1 immediately, no wr_d/wr2_c. After release with START=1, a fresh full 16-bit frame runs.
- Timing: HALF_PERIOD=2 build → SCLK period 4 clk. CS_SETUP and CS_HOLD are each 2 cycles. miso is sampled only at sclk rising edges (model changes miso on falling edges).
